cov_diag_loader: RTL and testbench

- Sweeps the covariance estimator's read port bin by bin and element by element.
- Applies diagonal loading (R + δI, saturating) and forces each diagonal's imaginary part to zero.
- Streams the regularised Hermitian matrix to the downstream MVDR weight solver over a valid/ready interface.
- Sits between `covariance_est` and the matrix-inversion stage; one sweep per `start` pulse covers all NBINS bins.

---
 rtl/cov_pkg.sv | 27 ++
 rtl/q15_sat_add.sv | 22 ++
 rtl/cov_diag_loader.sv | 162 ++++++++++++++++
 tb/tb_cov_diag_loader.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cov_pkg.sv
// Shared constants, FSM state type and element helpers for the covariance
// read / diagonal-loading / weight-solver chain.
package cov_pkg;

  localparam int DW     = 16;
  localparam int NMICS  = 4;
  localparam int NBINS  = 129;
  localparam int NELEM  = NMICS * NMICS;
  localparam int BIN_W  = $clog2(NBINS);
  localparam int ELEM_W = 4;

  localparam logic signed [DW-1:0] Q15_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] Q15_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } state_t;

  // Row-major diagonal elements sit every NMICS+1 positions: 0, 5, 10, 15.
  function automatic logic is_diag(input logic [ELEM_W-1:0] elem);
    return (int'(elem) % (NMICS + 1)) == 0;
  endfunction

endpackage

// File: rtl/q15_sat_add.sv
// Combinational Q1.15 signed add, clamped to the representable range.
module q15_sat_add
  import cov_pkg::*;
(
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [DW-1:0] y_o
);

  logic signed [DW:0] sum;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  always_comb begin
    sum = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};
    if (sum[DW] != sum[DW-1]) begin
      y_o = sum[DW] ? Q15_MIN : Q15_MAX;
    end else begin
      y_o = sum[DW-1:0];
    end
  end

endmodule

// File: rtl/cov_diag_loader.sv
// Sweeps the covariance read port, adds delta to each diagonal (imag forced
// to zero) and streams the Hermitian matrix to the solver via valid/ready.
module cov_diag_loader #(
  parameter int                   NBINS   = cov_pkg::NBINS,
  parameter int                   NMICS   = cov_pkg::NMICS,
  parameter int                   DW      = cov_pkg::DW,
  parameter logic signed [DW-1:0] DELTA   = 16'sd328,
  parameter int                   TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic [$clog2(NBINS)-1:0]   cov_rd_bin,
  output logic [3:0]                 cov_rd_elem,
  output logic                       cov_rd_en,
  input  logic signed [DW-1:0]       cov_rd_re,
  input  logic signed [DW-1:0]       cov_rd_im,
  input  logic                       cov_rd_valid,
  output logic signed [DW-1:0]       m_re,
  output logic signed [DW-1:0]       m_im,
  output logic [$clog2(NBINS)-1:0]   m_bin,
  output logic [3:0]                 m_elem,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       done,
  output logic                       err
);

  localparam int BIN_W = $clog2(NBINS);
  localparam int NELEM = NMICS * NMICS;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  cov_pkg::state_t state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [3:0]         elem_q, elem_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic signed [DW-1:0] m_re_q, m_re_d;
  logic signed [DW-1:0] m_im_q, m_im_d;
  logic [BIN_W-1:0]   m_bin_q, m_bin_d;
  logic [3:0]         m_elem_q, m_elem_d;
  logic               m_last_q, m_last_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic signed [DW-1:0] loaded_re;
  logic               diag;

  q15_sat_add u_sat_add (
    .a_i (cov_rd_re),
    .b_i (DELTA),
    .y_o (loaded_re)
  );

  assign diag = cov_pkg::is_diag(elem_q);

  // NOTE: every next-state value gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    elem_d   = elem_q;
    wd_d     = wd_q;
    m_re_d   = m_re_q;
    m_im_d   = m_im_q;
    m_bin_d  = m_bin_q;
    m_elem_d = m_elem_q;
    m_last_d = m_last_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      cov_pkg::ST_IDLE: begin
        if (start) begin
          bin_d   = '0;
          elem_d  = '0;
          state_d = cov_pkg::ST_REQ;
        end
      end
      cov_pkg::ST_REQ: begin
        wd_d    = '0;
        state_d = cov_pkg::ST_WAIT;
      end
      cov_pkg::ST_WAIT: begin
        if (cov_rd_valid) begin
          m_re_d   = diag ? loaded_re : cov_rd_re;
          m_im_d   = diag ? '0 : cov_rd_im;
          m_bin_d  = bin_q;
          m_elem_d = elem_q;
          m_last_d = (elem_q == 4'(NELEM - 1));
          state_d  = cov_pkg::ST_OUT;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          // Data arriving on the final watchdog cycle still wins over abort.
          err_d   = 1'b1;
          state_d = cov_pkg::ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      cov_pkg::ST_OUT: begin
        if (m_ready) begin
          if (elem_q != 4'(NELEM - 1)) begin
            elem_d  = elem_q + 1'b1;
            state_d = cov_pkg::ST_REQ;
          end else if (bin_q != BIN_W'(NBINS - 1)) begin
            bin_d   = bin_q + 1'b1;
            elem_d  = '0;
            state_d = cov_pkg::ST_REQ;
          end else begin
            done_d  = 1'b1;
            state_d = cov_pkg::ST_IDLE;
          end
        end
      end
      default: state_d = cov_pkg::ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values; reset here is synchronous, checked first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= cov_pkg::ST_IDLE;
      bin_q    <= '0;
      elem_q   <= '0;
      wd_q     <= '0;
      m_re_q   <= '0;
      m_im_q   <= '0;
      m_bin_q  <= '0;
      m_elem_q <= '0;
      m_last_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      elem_q   <= elem_d;
      wd_q     <= wd_d;
      m_re_q   <= m_re_d;
      m_im_q   <= m_im_d;
      m_bin_q  <= m_bin_d;
      m_elem_q <= m_elem_d;
      m_last_q <= m_last_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy        = (state_q != cov_pkg::ST_IDLE);
  assign cov_rd_en   = (state_q == cov_pkg::ST_REQ);
  assign m_valid     = (state_q == cov_pkg::ST_OUT);
  assign cov_rd_bin  = bin_q;
  assign cov_rd_elem = elem_q;
  assign m_re        = m_re_q;
  assign m_im        = m_im_q;
  assign m_bin       = m_bin_q;
  assign m_elem      = m_elem_q;
  assign m_last      = m_last_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cov_diag_loader.sv
// Directed bench for cov_diag_loader with a variable-latency covariance stub.
module tb_cov_diag_loader;

  localparam int NB = 129;
  localparam int NE = 16;
  localparam int BW = $clog2(NB);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic [BW-1:0] cov_rd_bin;
  logic [3:0] cov_rd_elem;
  logic cov_rd_en;
  logic signed [15:0] cov_rd_re = '0;
  logic signed [15:0] cov_rd_im = '0;
  logic cov_rd_valid = 1'b0;
  logic signed [15:0] m_re, m_im;
  logic [BW-1:0] m_bin;
  logic [3:0] m_elem;
  logic m_last, m_valid;
  logic m_ready = 1'b1;
  logic done, err;

  int n_cmp = 0;
  int n_bad = 0;
  int stub_lat = 2;
  bit stub_mute = 1'b0;

  always #5 clk = ~clk;

  cov_diag_loader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .cov_rd_bin(cov_rd_bin), .cov_rd_elem(cov_rd_elem), .cov_rd_en(cov_rd_en),
    .cov_rd_re(cov_rd_re), .cov_rd_im(cov_rd_im), .cov_rd_valid(cov_rd_valid),
    .m_re(m_re), .m_im(m_im), .m_bin(m_bin), .m_elem(m_elem),
    .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .done(done), .err(err)
  );

  function automatic logic signed [15:0] gen_re(input int b, input int e);
    int v;
    logic [15:0] t;
    if (b == 0 && e == 0) return 16'sd2048;
    if (b == 0 && (e == 1 || e == 4)) return 16'sd0;
    if (b == 0 && e == 5) return 16'sd32700;
    v = b * 613 + e * 4099 + 12345;
    t = v[15:0];
    return $signed(t);
  endfunction

  function automatic logic signed [15:0] gen_im(input int b, input int e);
    int v;
    logic [15:0] t;
    if (b == 0 && e == 0) return 16'sd0;
    if (b == 0 && e == 1) return -16'sd2048;
    if (b == 0 && e == 4) return 16'sd2048;
    if (b == 0 && e == 5) return 16'sd17;
    v = b * 211 + e * 977 + 999;
    t = v[15:0];
    return $signed(t);
  endfunction

  function automatic logic signed [15:0] exp_re(input int b, input int e);
    int s;
    logic [15:0] t;
    if (e % 5 != 0) return gen_re(b, e);
    s = int'(gen_re(b, e)) + 328;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    t = s[15:0];
    return $signed(t);
  endfunction

  function automatic logic signed [15:0] exp_im(input int b, input int e);
    return (e % 5 == 0) ? 16'sd0 : gen_im(b, e);
  endfunction

  // Covariance stub: answers each read strobe after stub_lat rising edges.
  initial begin
    int sb, se, sl;
    forever begin
      @(negedge clk);
      if (cov_rd_en === 1'b1 && !stub_mute) begin
        sb = int'(cov_rd_bin);
        se = int'(cov_rd_elem);
        sl = stub_lat;
        @(posedge clk);
        repeat (sl - 1) @(posedge clk);
        #1;
        cov_rd_valid = 1'b1;
        cov_rd_re    = gen_re(sb, se);
        cov_rd_im    = gen_im(sb, se);
        @(posedge clk);
        #1;
        cov_rd_valid = 1'b0;
        cov_rd_re    = '0;
        cov_rd_im    = '0;
      end
    end
  end

  initial begin
    #700000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  // Leaves the caller just after edge N (start sampled), inside cycle N+1.
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, m_valid, cov_rd_en, done, err, m_last} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got busy/mv/en/done/err/last=%b want 000000",
               {busy, m_valid, cov_rd_en, done, err, m_last});
    end
    n_cmp++;
    if ({m_re, m_im} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: got re=%0d im=%0d want 0 0", m_re, m_im);
    end
    n_cmp++;
    if ({m_bin, m_elem, cov_rd_bin, cov_rd_elem} !== '0) begin
      n_bad++;
      $display("FAIL reset_tags: got m_bin=%0d m_elem=%0d rd_bin=%0d rd_elem=%0d want 0",
               m_bin, m_elem, cov_rd_bin, cov_rd_elem);
    end
    rst = 1'b0;
  endtask

  task automatic test_loading();
    int e_exp = 0;
    int prev_req = 0;
    stub_lat = 2;
    m_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if ({busy, cov_rd_en, cov_rd_bin, cov_rd_elem} !== {2'b11, 8'd0, 4'd0}) begin
      n_bad++;
      $display("FAIL start_req: got busy=%b en=%b bin=%0d elem=%0d want 1 1 0 0",
               busy, cov_rd_en, cov_rd_bin, cov_rd_elem);
    end
    for (int t = 1; t < 200 && e_exp < 6; t++) begin
      @(negedge clk);
      if (cov_rd_en === 1'b1) begin
        n_cmp++;
        if (t - prev_req != 4) begin
          n_bad++;
          $display("FAIL elem_period: got %0d cycles want 4", t - prev_req);
        end
        prev_req = t;
      end
      if (m_valid === 1'b1) begin
        if (e_exp == 0) begin
          n_cmp++;
          if (t != 3) begin
            n_bad++;
            $display("FAIL first_latency: m_valid at cycle %0d want 3", t);
          end
        end
        n_cmp++;
        if (m_re !== exp_re(0, e_exp)) begin
          n_bad++;
          $display("FAIL load_re e%0d: got %0d want %0d", e_exp, m_re, exp_re(0, e_exp));
        end
        n_cmp++;
        if (m_im !== exp_im(0, e_exp)) begin
          n_bad++;
          $display("FAIL load_im e%0d: got %0d want %0d", e_exp, m_im, exp_im(0, e_exp));
        end
        n_cmp++;
        if ({m_bin, m_elem, m_last} !== {8'd0, 4'(e_exp), 1'b0}) begin
          n_bad++;
          $display("FAIL load_tag e%0d: got bin=%0d elem=%0d last=%b want 0 %0d 0",
                   e_exp, m_bin, m_elem, m_last, e_exp);
        end
        if (e_exp == 5) stub_lat = 3;
        e_exp++;
      end
    end
    n_cmp++;
    if (e_exp != 6) begin
      n_bad++;
      $display("FAIL load_timeout: got %0d elements want 6", e_exp);
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] r0, i0;
    int k_valid = -1;
    @(negedge clk);
    n_cmp++;
    if ({cov_rd_en, cov_rd_elem} !== {1'b1, 4'd6}) begin
      n_bad++;
      $display("FAIL xfer_to_req: got en=%b elem=%0d want 1 6", cov_rd_en, cov_rd_elem);
    end
    m_ready = 1'b0;
    for (int k = 1; k <= 20 && k_valid < 0; k++) begin
      @(negedge clk);
      if (m_valid === 1'b1) k_valid = k;
      else if (cov_rd_en !== 1'b0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL bp_extra_req: got rd_en=%b at cycle %0d want 0", cov_rd_en, k);
      end
    end
    n_cmp++;
    if (k_valid != 4) begin
      n_bad++;
      $display("FAIL bp_latency: m_valid at cycle %0d want 4", k_valid);
    end
    r0 = m_re;
    i0 = m_im;
    n_cmp++;
    if (r0 !== exp_re(0, 6) || i0 !== exp_im(0, 6)) begin
      n_bad++;
      $display("FAIL bp_data: got %0d %0d want %0d %0d", r0, i0, exp_re(0, 6), exp_im(0, 6));
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if ({m_valid, cov_rd_en, m_bin, m_elem, m_last} !== {2'b10, 8'd0, 4'd6, 1'b0} ||
          m_re !== r0 || m_im !== i0) begin
        n_bad++;
        $display("FAIL bp_hold c%0d: got mv=%b en=%b re=%0d im=%0d elem=%0d want 1 0 %0d %0d 6",
                 i, m_valid, cov_rd_en, m_re, m_im, m_elem, r0, i0);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cov_rd_en, m_valid, cov_rd_elem} !== {2'b10, 4'd7}) begin
      n_bad++;
      $display("FAIL bp_release: got en=%b mv=%b elem=%0d want 1 0 7",
               cov_rd_en, m_valid, cov_rd_elem);
    end
  endtask

  task automatic test_full_sweep();
    int xfers = 0, dones = 0, last_xfer = -10, sweep_bad = 0, tail = 0;
    int b_exp = 0, e_exp = 0, mid = 0;
    bit fin = 1'b0;
    do_reset();
    pulse_start();
    for (int c = 0; c < 40000 && tail < 4 && sweep_bad < 10; c++) begin
      @(negedge clk);
      if (mid == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL mid_start_busy: got %b want 1", busy);
        end
      end
      if (done === 1'b1) begin
        dones++;
        fin = 1'b1;
        n_cmp++;
        if (xfers != 2064 || busy !== 1'b0 || last_xfer != c - 1) begin
          n_bad++;
          $display("FAIL done_pulse: got xfers=%0d busy=%b gap=%0d want 2064 0 1",
                   xfers, busy, c - last_xfer);
        end
      end
      if (fin) tail++;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        n_cmp++;
        if ({m_bin, m_elem, m_last} !== {8'(b_exp), 4'(e_exp), e_exp == NE - 1} ||
            m_re !== exp_re(b_exp, e_exp) || m_im !== exp_im(b_exp, e_exp)) begin
          n_bad++;
          sweep_bad++;
          $display("FAIL sweep b%0d e%0d: got bin=%0d elem=%0d last=%b re=%0d im=%0d want re=%0d im=%0d",
                   b_exp, e_exp, m_bin, m_elem, m_last, m_re, m_im,
                   exp_re(b_exp, e_exp), exp_im(b_exp, e_exp));
        end
        xfers++;
        last_xfer = c;
        if (e_exp == NE - 1) begin
          e_exp = 0;
          b_exp++;
        end else begin
          e_exp++;
        end
      end
      @(posedge clk);
      #1;
      m_ready  = ($urandom_range(0, 3) != 0);
      stub_lat = $urandom_range(1, 3);
      if (mid == 1) begin
        start = 1'b0;
        mid = 2;
      end else if (mid == 0 && xfers >= 700) begin
        start = 1'b1;
        mid = 1;
      end
    end
    start = 1'b0;
    m_ready = 1'b1;
    n_cmp++;
    if (dones != 1 || xfers != 2064) begin
      n_bad++;
      $display("FAIL sweep_total: got dones=%0d xfers=%0d want 1 2064", dones, xfers);
    end
  endtask

  task automatic test_timeout();
    int k_err = -1;
    do_reset();
    stub_mute = 1'b1;
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if (cov_rd_en !== 1'b1) begin
      n_bad++;
      $display("FAIL to_req: got rd_en=%b want 1", cov_rd_en);
    end
    for (int k = 1; k <= 100 && k_err < 0; k++) begin
      @(negedge clk);
      if (err === 1'b1) k_err = k;
    end
    n_cmp++;
    if (k_err != 65) begin
      n_bad++;
      $display("FAIL to_err_time: err at cycle %0d want 65", k_err);
    end
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL to_err_state: got busy=%b done=%b want 0 0", busy, done);
    end
    @(negedge clk);
    n_cmp++;
    if ({err, busy, cov_rd_en, m_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL to_idle: got err/busy/en/mv=%b want 0000", {err, busy, cov_rd_en, m_valid});
    end
    stub_mute = 1'b0;
  endtask

  task automatic test_reset_midsweep();
    bit hit = 1'b0;
    int kv = -1;
    do_reset();
    stub_lat = 1;
    m_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 5000 && !hit; c++) begin
      @(negedge clk);
      if (cov_rd_bin === 8'd40) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL rst_reach_bin40: got bin=%0d want 40", cov_rd_bin);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, m_valid, cov_rd_en, done, err, m_last, m_re, m_im, m_bin, m_elem,
         cov_rd_bin, cov_rd_elem} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got busy=%b mv=%b en=%b re=%0d bin=%0d rd_bin=%0d want all 0",
               busy, m_valid, cov_rd_en, m_re, m_bin, cov_rd_bin);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pulse_start();
    @(negedge clk);
    n_cmp++;
    if ({cov_rd_en, cov_rd_bin, cov_rd_elem} !== {1'b1, 8'd0, 4'd0}) begin
      n_bad++;
      $display("FAIL rst_restart: got en=%b bin=%0d elem=%0d want 1 0 0",
               cov_rd_en, cov_rd_bin, cov_rd_elem);
    end
    for (int k = 1; k <= 10 && kv < 0; k++) begin
      @(negedge clk);
      if (m_valid === 1'b1) kv = k;
    end
    n_cmp++;
    if (kv < 0 || m_re !== 16'sd2376 || m_im !== 16'sd0 || {m_bin, m_elem} !== 12'd0) begin
      n_bad++;
      $display("FAIL rst_first_elem: got re=%0d im=%0d bin=%0d elem=%0d want 2376 0 0 0",
               m_re, m_im, m_bin, m_elem);
    end
  endtask

  initial begin
    test_reset();
    test_loading();
    test_backpressure();
    test_full_sweep();
    test_timeout();
    test_reset_midsweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
